// File: rtl/tb_run_ctrl_if.sv
// Control and core-wrapper signals of the run sequencer; master is the sequencer, slave is the bench/wrapper side.
interface tb_run_ctrl_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 start_i;
   logic [CNT_WIDTH-1:0] max_cycles_i;
   logic                 tests_passed_i;
   logic                 tests_failed_i;
   logic                 exit_valid_i;
   logic [31:0]          exit_value_i;
   logic                 core_rst_no;
   logic                 fetch_enable_o;
   logic                 done_o;
   logic [2:0]           status_o;
   logic [31:0]          exit_code_o;
   logic [CNT_WIDTH-1:0] cycle_count_o;
   logic                 tick_o;

   modport master (
      input  start_i, max_cycles_i, tests_passed_i, tests_failed_i, exit_valid_i, exit_value_i,
      output core_rst_no, fetch_enable_o, done_o, status_o, exit_code_o, cycle_count_o, tick_o
   );

   modport slave (
      output start_i, max_cycles_i, tests_passed_i, tests_failed_i, exit_valid_i, exit_value_i,
      input  core_rst_no, fetch_enable_o, done_o, status_o, exit_code_o, cycle_count_o, tick_o
   );
endinterface

// File: rtl/tb_run_ctrl.sv
// Run sequencer: reset hold, boot delay, run with pass/fail/exit/watchdog capture; heartbeat under TB_RUN_CTRL_HEARTBEAT_EN.
// Fetch rises RESET_HOLD_CYCLES+FETCH_DELAY_CYCLES+1 cycles after start; no backpressure, start ignored mid-run.
module tb_run_ctrl #(
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter int FETCH_DELAY_CYCLES = 4,
   parameter int CNT_WIDTH          = 32,
   parameter int HEARTBEAT_PERIOD   = 100000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   tb_run_ctrl_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_RSTH, S_BOOT, S_RUN, S_DONE} state_e;

   localparam logic [2:0] ST_NONE     = 3'd0;
   localparam logic [2:0] ST_PASSED   = 3'd1;
   localparam logic [2:0] ST_FAILED   = 3'd2;
   localparam logic [2:0] ST_EXIT_OK  = 3'd3;
   localparam logic [2:0] ST_EXIT_ERR = 3'd4;
   localparam logic [2:0] ST_TIMEOUT  = 3'd5;

   state_e               state_q, state_d;
   logic [31:0]          phase_q, phase_d;
   logic [CNT_WIDTH-1:0] limit_q, limit_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
   logic [2:0]           status_q, status_d;
   logic [31:0]          code_q, code_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         limit_q  <= '0;
         cnt_q    <= '0;
         status_q <= ST_NONE;
         code_q   <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         limit_q  <= limit_d;
         cnt_q    <= cnt_d;
         status_q <= status_d;
         code_q   <= code_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      limit_d  = limit_q;
      cnt_d    = cnt_q;
      status_d = status_q;
      code_d   = code_q;
      cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start_i) begin
               state_d  = S_RSTH;
               limit_d  = bus.max_cycles_i;
               phase_d  = '0;
               cnt_d    = '0;
               status_d = ST_NONE;
               code_d   = '0;
            end
         end
         S_RSTH: begin
            if (phase_q == 32'(RESET_HOLD_CYCLES - 1)) begin
               state_d = S_BOOT;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         S_BOOT: begin
            if (phase_q == 32'(FETCH_DELAY_CYCLES - 1)) begin
               state_d = S_RUN;
               phase_d = '0;
               cnt_d   = '0;
            end else begin
               phase_d = phase_q + 32'd1;
            end
         end
         S_RUN: begin
            // The terminating cycle still counts, so an event on RUN cycle k reports k.
            cnt_d = cnt_inc;
            if (bus.tests_failed_i) begin
               state_d  = S_DONE;
               status_d = ST_FAILED;
            end else if (bus.tests_passed_i) begin
               state_d  = S_DONE;
               status_d = ST_PASSED;
            end else if (bus.exit_valid_i) begin
               state_d  = S_DONE;
               status_d = (bus.exit_value_i == 32'd0) ? ST_EXIT_OK : ST_EXIT_ERR;
               code_d   = bus.exit_value_i;
            end else if ((limit_q != '0) && (cnt_inc == limit_q)) begin
               state_d  = S_DONE;
               status_d = ST_TIMEOUT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.core_rst_no    = (state_q == S_BOOT) || (state_q == S_RUN) || (state_q == S_DONE);
   assign bus.fetch_enable_o = (state_q == S_RUN);
   assign bus.done_o         = (state_q == S_DONE);
   assign bus.status_o       = status_q;
   assign bus.exit_code_o    = code_q;
   assign bus.cycle_count_o  = cnt_q;

`ifdef TB_RUN_CTRL_HEARTBEAT_EN
   logic [31:0] hb_q, hb_d;
   logic        tick_q, tick_d;

   always_comb begin
      hb_d   = hb_q;
      tick_d = 1'b0;
      if (state_q == S_BOOT && state_d == S_RUN) begin
         hb_d = '0;
      end else if (state_q == S_RUN) begin
         // Tick lands on the same edge that makes cycle_count_o a multiple of the period.
         if (hb_q == 32'(HEARTBEAT_PERIOD - 1)) begin
            hb_d   = '0;
            tick_d = 1'b1;
         end else begin
            hb_d = hb_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hb_q   <= '0;
         tick_q <= 1'b0;
      end else begin
         hb_q   <= hb_d;
         tick_q <= tick_d;
      end
   end

   assign bus.tick_o = tick_q;
`else
   assign bus.tick_o = 1'b0;
`endif
endmodule

// File: tb/tb_tb_run_ctrl.sv
// Directed bench for tb_run_ctrl: expected run outcomes are queued at stimulus time and popped when done_o rises.
module tb_tb_run_ctrl;
   localparam int CW = 32;
   localparam int RH = 16;
   localparam int FD = 4;
   localparam int HB = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tb_run_ctrl_if #(.CNT_WIDTH(CW)) bus ();

   tb_run_ctrl #(
      .RESET_HOLD_CYCLES (RH),
      .FETCH_DELAY_CYCLES(FD),
      .CNT_WIDTH         (CW),
      .HEARTBEAT_PERIOD  (HB)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   typedef struct {
      logic [2:0]  status;
      logic [31:0] code;
      logic [31:0] count;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] s, input logic [31:0] c, input logic [31:0] n);
      exp_t e;
      e.status = s;
      e.code   = c;
      e.count  = n;
      sb.push_back(e);
   endtask

   task automatic start_run(input logic [31:0] lim);
      bus.max_cycles_i = lim;
      bus.start_i      = 1'b1;
      step();
      bus.start_i      = 1'b0;
   endtask

   // Called in the first cycle after the start edge; fetch must rise RH+FD edges later.
   task automatic wait_fetch();
      int n;
      n = 0;
      while (bus.fetch_enable_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("fetch_latency", n, RH + FD);
   endtask

   task automatic wait_done(input int budget);
      int   n;
      exp_t e;
      n = 0;
      while (bus.done_o !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk("done_seen", bus.done_o, 1);
      chk("sb_pending", sb.size(), 1);
      if (bus.done_o === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         chk("status", bus.status_o, e.status);
         chk("exit_code", bus.exit_code_o, e.code);
         chk("cycle_count", bus.cycle_count_o, e.count);
         chk("done_fetch_low", bus.fetch_enable_o, 0);
         chk("done_core_rst_high", bus.core_rst_no, 1);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_core_rst_no"}, bus.core_rst_no, 0);
      chk({tag, "_fetch"}, bus.fetch_enable_o, 0);
      chk({tag, "_done"}, bus.done_o, 0);
      chk({tag, "_status"}, bus.status_o, 0);
      chk({tag, "_code"}, bus.exit_code_o, 0);
      chk({tag, "_count"}, bus.cycle_count_o, 0);
      chk({tag, "_tick"}, bus.tick_o, 0);
   endtask

   initial begin
      bit hb_en;
`ifdef TB_RUN_CTRL_HEARTBEAT_EN
      hb_en = 1'b1;
`else
      hb_en = 1'b0;
`endif
      bus.start_i        = 1'b0;
      bus.max_cycles_i   = '0;
      bus.tests_passed_i = 1'b0;
      bus.tests_failed_i = 1'b0;
      bus.exit_valid_i   = 1'b0;
      bus.exit_value_i   = '0;
      rst = 1'b1;
      step();
      step();
      chk_reset_values("reset");
      rst = 1'b0;

      // Boot sequence timing and PASSED on the 10th RUN cycle
      start_run(32'd0);
      for (int k = 1; k <= 21; k++) begin
         chk("boot_core_rst_no", bus.core_rst_no, (k >= 17) ? 1 : 0);
         chk("boot_fetch", bus.fetch_enable_o, (k >= 21) ? 1 : 0);
         if (k < 21) step();
      end
      chk("run_first_count", bus.cycle_count_o, 0);
      repeat (9) step();
      chk("run_count_9", bus.cycle_count_o, 9);
      bus.tests_passed_i = 1'b1;
      push(3'd1, 32'd0, 32'd10);
      step();
      bus.tests_passed_i = 1'b0;
      wait_done(5);

      // Restart from DONE clears results; FAILED beats simultaneous exit
      start_run(32'd0);
      chk("restart_done", bus.done_o, 0);
      chk("restart_status", bus.status_o, 0);
      chk("restart_count", bus.cycle_count_o, 0);
      chk("restart_core_rst_no", bus.core_rst_no, 0);
      wait_fetch();
      bus.tests_failed_i = 1'b1;
      bus.exit_valid_i   = 1'b1;
      bus.exit_value_i   = 32'd0;
      push(3'd2, 32'd0, 32'd1);
      step();
      bus.tests_failed_i = 1'b0;
      bus.exit_valid_i   = 1'b0;
      wait_done(5);

      // EXIT_ERR with code 0x2A on RUN cycle 4
      start_run(32'd0);
      wait_fetch();
      repeat (3) step();
      bus.exit_valid_i = 1'b1;
      bus.exit_value_i = 32'h2A;
      push(3'd4, 32'h2A, 32'd4);
      step();
      bus.exit_valid_i = 1'b0;
      bus.exit_value_i = 32'd0;
      wait_done(5);

      // EXIT_OK on the first RUN cycle
      start_run(32'd0);
      wait_fetch();
      bus.exit_valid_i = 1'b1;
      push(3'd3, 32'd0, 32'd1);
      step();
      bus.exit_valid_i = 1'b0;
      wait_done(5);

      // Watchdog of 50 RUN cycles
      start_run(32'd50);
      wait_fetch();
      repeat (49) step();
      chk("timeout_not_early", bus.done_o, 0);
      chk("timeout_count_49", bus.cycle_count_o, 49);
      push(3'd5, 32'd0, 32'd50);
      wait_done(5);

      // No limit; events outside RUN and start during RUN must be ignored
      start_run(32'd0);
      bus.tests_passed_i = 1'b1;
      bus.tests_failed_i = 1'b1;
      wait_fetch();
      bus.tests_passed_i = 1'b0;
      bus.tests_failed_i = 1'b0;
      for (int k = 1; k <= 10000; k++) begin
         if (k == 5) begin
            bus.max_cycles_i = 32'd3;
            bus.start_i      = 1'b1;
         end
         step();
         bus.start_i = 1'b0;
         if (k <= 40) begin
            chk("tick", bus.tick_o, (hb_en && (k % HB) == 0) ? 1 : 0);
            chk("run_still_fetch", bus.fetch_enable_o, 1);
         end
      end
      chk("nolimit_done", bus.done_o, 0);
      chk("nolimit_fetch", bus.fetch_enable_o, 1);
      chk("nolimit_count", bus.cycle_count_o, 10000);

      // Reset mid-RUN, then a full run from IDLE
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_values("midrun_reset");
      start_run(32'd0);
      wait_fetch();
      step();
      bus.tests_passed_i = 1'b1;
      push(3'd1, 32'd0, 32'd2);
      step();
      bus.tests_passed_i = 1'b0;
      wait_done(5);

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tb_run_ctrl.md
Name: tb_run_ctrl

Overview:
- Sequences a single simulation run of the core testbench wrapper.
- Holds the core in reset for a fixed number of cycles, then releases reset, then asserts fetch enable after a delay.
- While the run executes, it watches the pass, fail and exit indications plus a cycle watchdog.
- Captures one final status and exit code and halts fetch, so the top-level bench only reacts to done_o instead of open-coding these checks.

Parameters:
- RESET_HOLD_CYCLES, 16: cycles core_rst_no is held low after start (min 1).
- FETCH_DELAY_CYCLES, 4: cycles between reset release and fetch_enable_o assertion (min 1).
- CNT_WIDTH, 32: width of the run-cycle counter and the watchdog limit.
- HEARTBEAT_PERIOD, 100000: RUN cycles between tick_o pulses. Only used with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  single-cycle pulse that begins or restarts a run. Accepted in IDLE or DONE only.
- max_cycles_i  in  CNT_WIDTH  watchdog limit, latched on an accepted start_i. 0 means no limit.
- tests_passed_i  in  1  pass flag from the wrapper
- tests_failed_i  in  1  fail flag from the wrapper
- exit_valid_i  in  1  exit-request strobe from the wrapper
- exit_value_i  in  32  exit code, qualified by exit_valid_i
- core_rst_no  out  1  active-low reset to the core wrapper
- fetch_enable_o  out  1  fetch enable to the core wrapper
- done_o  out  1  run finished. Sticky until start_i or rst_i.
- status_o  out  3  0 NONE, 1 PASSED, 2 FAILED, 3 EXIT_OK, 4 EXIT_ERR, 5 TIMEOUT
- exit_code_o  out  32  captured exit_value_i. 0 unless the status is EXIT_OK or EXIT_ERR.
- cycle_count_o  out  CNT_WIDTH  number of RUN-state cycles elapsed, saturating
- tick_o  out  1  heartbeat pulse

Behaviour:
- Reset values (rst_i=1 at a clock edge):
  - state IDLE
  - core_rst_no=0, fetch_enable_o=0, done_o=0
  - status_o=0, exit_code_o=0, cycle_count_o=0, tick_o=0
  - latched limit 0, all internal counters 0
- rst_i has priority over every other input, including mid-run: the core goes straight back into reset.
- States and outputs:
  - IDLE: core_rst_no=0, fetch_enable_o=0. start_i=1 moves to RSTH next cycle and latches max_cycles_i.
  - RSTH: core_rst_no=0 for exactly RESET_HOLD_CYCLES cycles, then moves to BOOT.
  - BOOT: core_rst_no=1, fetch_enable_o=0 for exactly FETCH_DELAY_CYCLES cycles, then moves to RUN.
  - RUN: core_rst_no=1, fetch_enable_o=1. The run counter is cleared on RUN entry, so the first RUN cycle reads 0. It increments on every RUN cycle, including the terminating one, and saturates at all-ones.
  - DONE: core_rst_no=1, fetch_enable_o=0, done_o=1. Status, code and count are held.
- RUN termination is evaluated each RUN cycle. The highest-priority true condition wins; the state moves to DONE on the next edge and status/code are registered on that edge:
  1. tests_failed_i -> FAILED
  2. tests_passed_i -> PASSED
  3. exit_valid_i -> EXIT_OK if exit_value_i==0, else EXIT_ERR; exit_code_o=exit_value_i
  4. limit!=0 and count+1==limit -> TIMEOUT
- Timing consequences:
  - With limit N, a TIMEOUT run spends exactly N cycles in RUN and final cycle_count_o=N.
  - An event on the first RUN cycle gives cycle_count_o=1.
- tests_passed_i, tests_failed_i and exit_valid_i are ignored outside RUN.
- start_i handling:
  - start_i in DONE clears done_o, status_o, exit_code_o and cycle_count_o on the next edge and enters RSTH with the newly latched limit.
  - start_i in RSTH, BOOT or RUN is ignored.
- Start-to-fetch latency: fetch_enable_o first rises RESET_HOLD_CYCLES+FETCH_DELAY_CYCLES+1 cycles after the start_i edge.

Optional Feature:
- Macro TB_RUN_CTRL_HEARTBEAT_EN.
- Defined: a free-running heartbeat counter runs only in RUN and resets on RUN entry. tick_o pulses for one cycle on every HEARTBEAT_PERIOD-th RUN cycle, i.e. when cycle_count_o becomes a multiple of HEARTBEAT_PERIOD.
- Not defined: tick_o is tied to 0, no heartbeat counter is instantiated, and HEARTBEAT_PERIOD is unused.

Test Plan:
- Defaults, start_i pulse at cycle 0 -> core_rst_no low cycles 1-16, high from cycle 17; fetch_enable_o rises at cycle 21.
- RUN, tests_passed_i asserted on the 10th RUN cycle -> next cycle done_o=1, status_o=1, cycle_count_o=10, fetch_enable_o=0.
- tests_failed_i and exit_valid_i (value 0) asserted in the same RUN cycle -> status_o=2 (FAILED), exit_code_o=0.
- exit_valid_i with exit_value_i=0x2A -> status_o=4 (EXIT_ERR), exit_code_o=0x2A. With exit_value_i=0 -> status_o=3 (EXIT_OK).
- max_cycles_i=50, no events -> status_o=5 (TIMEOUT) after exactly 50 RUN cycles, cycle_count_o=50. Repeat with max_cycles_i=0 for 10000 cycles -> still RUN, done_o=0.
- rst_i pulsed mid-RUN -> next cycle core_rst_no=0, fetch_enable_o=0, all outputs at reset values. Then start_i from DONE -> status cleared and the full sequence repeats. With TB_RUN_CTRL_HEARTBEAT_EN and HEARTBEAT_PERIOD=8 -> tick_o high when cycle_count_o reaches 8, 16, 24.
